// File: rtl/fpu_op_sequencer_if.sv
// fpu_op_sequencer_if
//   Bundles the issue handshake, the shared FP-unit control/response bus, and
//   the writeback / branch-resolve / error outputs of the FPU issue sequencer.
//
//   Groups:
//     issue  : iss_valid, iss_ready, iss_opcode[4:0], iss_rd[4:0], iss_pc_tgt[31:0], flush
//     unit   : unit_sel[6:0] (one-hot {COM,ABS,INV,DIV,MUL,SUB,ADD}), unit_imm,
//              unit_start, unit_abort, unit_done, unit_result[31:0],
//              unit_lt, unit_eq, unit_gt
//     result : wb_valid, wb_rd[4:0], wb_data[31:0],
//              br_valid, br_taken, br_target[31:0]
//     error  : err_illegal, err_timeout
//
//   master : the sequencer side
//   slave  : the environment side (decode stage, FP units, consumers)
interface fpu_op_sequencer_if;
  logic        iss_valid;
  logic        iss_ready;
  logic [4:0]  iss_opcode;
  logic [4:0]  iss_rd;
  logic [31:0] iss_pc_tgt;
  logic        flush;

  logic [6:0]  unit_sel;
  logic        unit_imm;
  logic        unit_start;
  logic        unit_abort;
  logic        unit_done;
  logic [31:0] unit_result;
  logic        unit_lt;
  logic        unit_eq;
  logic        unit_gt;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        err_illegal;
  logic        err_timeout;

  modport master (
    input  iss_valid, iss_opcode, iss_rd, iss_pc_tgt, flush,
    input  unit_done, unit_result, unit_lt, unit_eq, unit_gt,
    output iss_ready,
    output unit_sel, unit_imm, unit_start, unit_abort,
    output wb_valid, wb_rd, wb_data,
    output br_valid, br_taken, br_target,
    output err_illegal, err_timeout
  );

  modport slave (
    output iss_valid, iss_opcode, iss_rd, iss_pc_tgt, flush,
    output unit_done, unit_result, unit_lt, unit_eq, unit_gt,
    input  iss_ready,
    input  unit_sel, unit_imm, unit_start, unit_abort,
    input  wb_valid, wb_rd, wb_data,
    input  br_valid, br_taken, br_target,
    input  err_illegal, err_timeout
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer
//   Issue sequencer for the FPU execution path. Accepts one decoded FPU
//   instruction at a time, starts exactly one shared FP unit, waits for its
//   completion and emits either a register writeback or a resolved branch.
//
//   Parameters:
//     TIMEOUT : number of WAIT cycles without unit_done tolerated; a done in
//               the TIMEOUT-th WAIT cycle still completes, otherwise
//               unit_abort + err_timeout pulse in the following cycle (2..255)
//
//   Ports:
//     clk   : clock, all state on the rising edge
//     rst_n : asynchronous active-low reset
//     bus   : fpu_op_sequencer_if.master (issue, unit, result, error groups)
//
//   Timing: accept in N -> unit_start in N+1 -> earliest unit_done in N+2
//   -> wb_valid / br_valid in N+3. Every output is registered except
//   iss_ready, and except wb_valid/br_valid, which are masked by a flush
//   arriving in the same cycle so a flushed result never reaches a consumer.
module fpu_op_sequencer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  fpu_op_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB,
    S_BR
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       nop;
    logic       imm;
    logic [6:0] sel;
  } dec_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  // Register ops 00001..00111 and immediate ops 10001..10110 share the unit
  // index in opcode[2:0]; branches 11100..11110 all use the comparator.
  function automatic dec_t decode_op(input logic [4:0] op);
    dec_t d;
    d = '0;
    if (op == 5'b00000) begin
      d.legal = 1'b1;
      d.nop   = 1'b1;
    end else if (op[4:3] == 2'b00) begin
      d.legal = 1'b1;
      d.sel   = 7'b0000001 << (op[2:0] - 3'd1);
    end else if (op[4:3] == 2'b10 && op[2:0] != 3'b000 && op[2:0] != 3'b111) begin
      d.legal = 1'b1;
      d.imm   = 1'b1;
      d.sel   = 7'b0000001 << (op[2:0] - 3'd1);
    end else if (op[4:2] == 3'b111 && op[1:0] != 2'b11) begin
      d.legal = 1'b1;
      d.sel   = 7'b1000000;
    end
    return d;
  endfunction

  state_t      state_reg;
  logic [4:0]  opcode_reg;
  logic [4:0]  rd_reg;
  logic [31:0] pc_tgt_reg;
  logic [7:0]  watchdog_reg;

  logic [6:0]  unit_sel_reg;
  logic        unit_imm_reg;
  logic        unit_start_reg;
  logic        unit_abort_reg;
  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic        br_valid_reg;
  logic        br_taken_reg;
  logic [31:0] br_target_reg;
  logic        err_illegal_reg;
  logic        err_timeout_reg;

  dec_t        iss_dec;
  logic [8:0]  wd_inc;
  logic        is_branch;
  logic        branch_flag;

  assign iss_dec   = decode_op(bus.iss_opcode);
  assign wd_inc    = {1'b0, watchdog_reg} + 9'd1;
  assign is_branch = (opcode_reg[4:2] == 3'b111);

  // Only legal branches reach WAIT, so opcode[1:0] is 00 BEQ, 01 BLT, 10 BGT.
  always_comb begin
    case (opcode_reg[1:0])
      2'b00:   branch_flag = bus.unit_eq;
      2'b01:   branch_flag = bus.unit_lt;
      default: branch_flag = bus.unit_gt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      opcode_reg      <= '0;
      rd_reg          <= '0;
      pc_tgt_reg      <= '0;
      watchdog_reg    <= '0;
      unit_sel_reg    <= '0;
      unit_imm_reg    <= 1'b0;
      unit_start_reg  <= 1'b0;
      unit_abort_reg  <= 1'b0;
      wb_valid_reg    <= 1'b0;
      wb_rd_reg       <= '0;
      wb_data_reg     <= '0;
      br_valid_reg    <= 1'b0;
      br_taken_reg    <= 1'b0;
      br_target_reg   <= '0;
      err_illegal_reg <= 1'b0;
      err_timeout_reg <= 1'b0;
    end else begin
      // One-cycle pulses default low; the state branches below raise them.
      unit_start_reg  <= 1'b0;
      unit_abort_reg  <= 1'b0;
      wb_valid_reg    <= 1'b0;
      br_valid_reg    <= 1'b0;
      err_illegal_reg <= 1'b0;
      err_timeout_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (bus.iss_valid && !bus.flush) begin
            opcode_reg <= bus.iss_opcode;
            rd_reg     <= bus.iss_rd;
            pc_tgt_reg <= bus.iss_pc_tgt;
            if (!iss_dec.legal) begin
              err_illegal_reg <= 1'b1;
            end else if (!iss_dec.nop) begin
              state_reg      <= S_ISSUE;
              unit_start_reg <= 1'b1;
              unit_sel_reg   <= iss_dec.sel;
              unit_imm_reg   <= iss_dec.imm;
            end
          end
        end

        S_ISSUE: begin
          watchdog_reg <= '0;
          if (bus.flush) begin
            unit_abort_reg <= 1'b1;
            unit_sel_reg   <= '0;
            unit_imm_reg   <= 1'b0;
            state_reg      <= S_IDLE;
          end else begin
            state_reg <= S_WAIT;
          end
        end

        S_WAIT: begin
          // Priority: flush, then done, then watchdog expiry.
          if (bus.flush) begin
            unit_abort_reg <= 1'b1;
            unit_sel_reg   <= '0;
            unit_imm_reg   <= 1'b0;
            state_reg      <= S_IDLE;
          end else if (bus.unit_done) begin
            unit_sel_reg <= '0;
            unit_imm_reg <= 1'b0;
            if (is_branch) begin
              br_valid_reg  <= 1'b1;
              br_taken_reg  <= branch_flag;
              br_target_reg <= pc_tgt_reg;
              state_reg     <= S_BR;
            end else begin
              wb_valid_reg <= 1'b1;
              wb_rd_reg    <= rd_reg;
              wb_data_reg  <= bus.unit_result;
              state_reg    <= S_WB;
            end
          end else begin
            watchdog_reg <= (watchdog_reg == 8'hFF) ? 8'hFF : wd_inc[7:0];
            if (wd_inc >= TIMEOUT_W) begin
              unit_abort_reg  <= 1'b1;
              err_timeout_reg <= 1'b1;
              unit_sel_reg    <= '0;
              unit_imm_reg    <= 1'b0;
              state_reg       <= S_IDLE;
            end
          end
        end

        S_WB: begin
          wb_rd_reg   <= '0;
          wb_data_reg <= '0;
          state_reg   <= S_IDLE;
        end

        S_BR: begin
          br_taken_reg  <= 1'b0;
          br_target_reg <= '0;
          state_reg     <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // A flush in IDLE also refuses the offer in that cycle.
  assign bus.iss_ready   = (state_reg == S_IDLE) && !bus.flush;
  assign bus.unit_sel    = unit_sel_reg;
  assign bus.unit_imm    = unit_imm_reg;
  assign bus.unit_start  = unit_start_reg;
  assign bus.unit_abort  = unit_abort_reg;
  assign bus.wb_valid    = wb_valid_reg && !bus.flush;
  assign bus.wb_rd       = wb_rd_reg;
  assign bus.wb_data     = wb_data_reg;
  assign bus.br_valid    = br_valid_reg && !bus.flush;
  assign bus.br_taken    = br_taken_reg;
  assign bus.br_target   = br_target_reg;
  assign bus.err_illegal = err_illegal_reg;
  assign bus.err_timeout = err_timeout_reg;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer
//   Scoreboard bench: each transaction computes its expected output pulses
//   from the opcode class rules and pushes them into a queue; an independent
//   monitor pops and compares whenever the sequencer raises any pulse.
module tb_fpu_op_sequencer;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_op_sequencer_if bus ();

  fpu_op_sequencer #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic [5:0]  pulses;   // {start, abort, wb, br, illegal, timeout}
    logic [6:0]  sel;
    logic        imm;
    logic [4:0]  rd;
    logic [31:0] data;     // wb_data or br_target
    logic        taken;
  } ev_t;

  localparam logic [5:0] P_START = 6'b100000;
  localparam logic [5:0] P_ABORT = 6'b010000;
  localparam logic [5:0] P_WB    = 6'b001000;
  localparam logic [5:0] P_BR    = 6'b000100;
  localparam logic [5:0] P_ILL   = 6'b000010;
  localparam logic [5:0] P_TMO   = 6'b010001;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Opcode classes: 0 NOP, 1 register op, 2 immediate op, 3 branch, 4 illegal.
  function automatic int op_class(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 0) return 0;
    if (v >= 1 && v <= 7) return 1;
    if (v >= 17 && v <= 22) return 2;
    if (v >= 28 && v <= 30) return 3;
    return 4;
  endfunction

  function automatic void push_ev(input int c, input logic [5:0] p, input logic [6:0] sel,
                                  input logic imm, input logic [4:0] rd, input logic [31:0] d,
                                  input logic tk);
    ev_t e;
    e.cyc = c; e.pulses = p; e.sel = sel; e.imm = imm; e.rd = rd; e.data = d; e.taken = tk;
    exp_q.push_back(e);
  endfunction

  function automatic logic [83:0] reg_outs();
    return {bus.unit_sel, bus.unit_imm, bus.unit_start, bus.unit_abort, bus.wb_valid,
            bus.wb_rd, bus.wb_data, bus.br_valid, bus.br_taken, bus.br_target,
            bus.err_illegal, bus.err_timeout};
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, got, req);
    end
  endtask

  // ---------------- monitor ----------------
  ev_t        mon_ev;
  logic [5:0] obs;
  bit         ok;

  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        mon_ev = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missing_pulse: cycle %0d got none required pulses %b at cycle %0d",
                 cyc, mon_ev.pulses, mon_ev.cyc);
      end
      obs = {bus.unit_start, bus.unit_abort, bus.wb_valid, bus.br_valid,
             bus.err_illegal, bus.err_timeout};
      if (obs != 6'b0) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse: cycle %0d got pulses %b required none", cyc, obs);
        end else begin
          mon_ev = exp_q.pop_front();
          ok = (mon_ev.cyc == cyc) && (obs == mon_ev.pulses);
          if (mon_ev.pulses[5]) ok = ok && (bus.unit_sel == mon_ev.sel) && (bus.unit_imm == mon_ev.imm);
          if (mon_ev.pulses[3]) ok = ok && (bus.wb_rd == mon_ev.rd) && (bus.wb_data == mon_ev.data);
          if (mon_ev.pulses[2]) ok = ok && (bus.br_taken == mon_ev.taken) && (bus.br_target == mon_ev.data);
          if (!ok) begin
            n_bad++;
            $display("FAIL pulse_event: got cyc=%0d pulses=%b sel=%b imm=%b rd=%0d wb=%h tk=%b tgt=%h required cyc=%0d pulses=%b sel=%b imm=%b rd=%0d data=%h tk=%b",
                     cyc, obs, bus.unit_sel, bus.unit_imm, bus.wb_rd, bus.wb_data, bus.br_taken,
                     bus.br_target, mon_ev.cyc, mon_ev.pulses, mon_ev.sel, mon_ev.imm, mon_ev.rd,
                     mon_ev.data, mon_ev.taken);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // fmode: 0 none, 1 flush in ISSUE/WAIT, 2 flush with done, 3 flush in WB/BR,
  //        4 flush in IDLE together with the offer.
  // lat: unit_done arrives lat cycles after the start cycle; lat > TMO never completes.
  // flg: {lt, eq, gt} presented with unit_done.
  task automatic run_txn(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] tgt,
                         input int lat, input int fmode_in, input logic [31:0] res,
                         input logic [2:0] flg, input bit spur);
    int a, cls, unit, fmode, done_c, flush_c, idle_from, sel_last, t_c, v;
    logic [6:0] esel;
    logic       eimm;
    logic       taken;
    a         = cyc;
    cls       = op_class(op);
    fmode     = fmode_in;
    v         = int'(op);
    done_c    = -1;
    flush_c   = -1;
    sel_last  = -1;
    idle_from = a + 1;
    t_c       = a + 1 + TMO;
    unit      = (cls == 1) ? v : (cls == 2) ? v - 16 : 7;
    esel      = 7'(1 << (unit - 1));
    eimm      = (cls == 2);
    taken     = (v == 28) ? flg[1] : (v == 29) ? flg[2] : flg[0];

    if (fmode == 4) begin
      flush_c = a;
    end else if (cls == 4) begin
      push_ev(a + 1, P_ILL, 7'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    end else if (cls != 0) begin
      push_ev(a + 1, P_START, esel, eimm, 5'd0, 32'd0, 1'b0);
      if (lat <= TMO) done_c = a + 1 + lat;
      if (done_c < 0 && fmode >= 2) fmode = 1;
      if (fmode == 1) flush_c = a + 1 + int'($urandom_range(0, (done_c < 0) ? TMO : lat - 1));
      else if (fmode == 2) flush_c = done_c;
      else if (fmode == 3) flush_c = done_c + 1;
      if (fmode == 1 || fmode == 2) begin
        push_ev(flush_c + 1, P_ABORT, 7'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        idle_from = flush_c + 1;
        sel_last  = flush_c;
      end else if (done_c >= 0) begin
        if (fmode != 3) begin
          if (cls == 3) push_ev(done_c + 1, P_BR, 7'd0, 1'b0, 5'd0, tgt, taken);
          else          push_ev(done_c + 1, P_WB, 7'd0, 1'b0, rd, res, 1'b0);
        end
        idle_from = done_c + 2;
        sel_last  = done_c;
      end else begin
        push_ev(t_c + 1, P_TMO, 7'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        idle_from = t_c + 1;
        sel_last  = t_c;
      end
    end

    $display("txn cycle=%0d op=%05b rd=%0d tgt=%h lat=%0d fmode=%0d spur=%0d", a, op, rd, tgt,
             lat, fmode, spur);
    bus.iss_valid  = 1'b1;
    bus.iss_opcode = op;
    bus.iss_rd     = rd;
    bus.iss_pc_tgt = tgt;
    bus.flush      = (fmode == 4);
    @(negedge clk);
    check("iss_ready_accept", 128'(bus.iss_ready), 128'(fmode != 4));

    for (int c = a + 1; c <= a + TMO + 6; c++) begin
      @(posedge clk); #1;
      bus.iss_valid   = 1'b0;
      bus.iss_opcode  = 5'($urandom);
      bus.iss_rd      = 5'($urandom);
      bus.iss_pc_tgt  = $urandom;
      bus.flush       = (c == flush_c);
      bus.unit_done   = (c == done_c) || (spur && c == a + 1);
      bus.unit_result = (c == done_c) ? res : $urandom;
      {bus.unit_lt, bus.unit_eq, bus.unit_gt} = (c == done_c) ? flg : 3'($urandom);
      @(negedge clk);
      check("iss_ready", 128'(bus.iss_ready), 128'((c >= idle_from) && (c != flush_c)));
      check("unit_sel_imm", 128'({bus.unit_sel, bus.unit_imm}),
            128'((c >= a + 1 && c <= sel_last) ? {esel, eimm} : 8'h00));
    end
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.unit_done = 1'b0;
  endtask

  initial begin
    int         a;
    int         k;
    logic [4:0] op;

    rst_n           = 1'b0;
    bus.iss_valid   = 1'b0;
    bus.iss_opcode  = '0;
    bus.iss_rd      = '0;
    bus.iss_pc_tgt  = '0;
    bus.flush       = 1'b0;
    bus.unit_done   = 1'b0;
    bus.unit_result = '0;
    bus.unit_lt     = 1'b0;
    bus.unit_eq     = 1'b0;
    bus.unit_gt     = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 128'(reg_outs()), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(bus.iss_ready), 128'(1));
    check("outputs_after_reset", 128'(reg_outs()), 128'(0));
    @(posedge clk); #1;

    // Directed cases
    run_txn(5'b00001, 5'd3,  32'h0,   2, 0, 32'h40400000, 3'b000, 1'b0); // ADD
    run_txn(5'b10011, 5'd7,  32'h0,   1, 0, 32'h3f800000, 3'b000, 1'b0); // MULIF
    run_txn(5'b11101, 5'd0,  32'h100, 3, 0, 32'h0,        3'b100, 1'b0); // BLT lt=1
    run_txn(5'b11100, 5'd0,  32'h200, 2, 0, 32'h0,        3'b101, 1'b0); // BEQ eq=0
    run_txn(5'b11110, 5'd0,  32'h300, 1, 0, 32'h0,        3'b001, 1'b0); // BGT gt=1
    run_txn(5'b01000, 5'd1,  32'h0,   1, 0, 32'h0,        3'b000, 1'b0); // illegal
    run_txn(5'b11111, 5'd1,  32'h0,   1, 0, 32'h0,        3'b000, 1'b0); // illegal
    run_txn(5'b00000, 5'd1,  32'h0,   1, 0, 32'h0,        3'b000, 1'b0); // NOP
    run_txn(5'b00001, 5'd4,  32'h0,   9, 0, 32'h0,        3'b000, 1'b0); // timeout
    run_txn(5'b00010, 5'd5,  32'h0,   4, 0, 32'hdeadbeef, 3'b000, 1'b0); // done on timeout cycle
    run_txn(5'b00011, 5'd6,  32'h0,   2, 2, 32'h11111111, 3'b000, 1'b0); // flush with done
    run_txn(5'b00100, 5'd7,  32'h0,   2, 3, 32'h22222222, 3'b000, 1'b0); // flush in WB
    run_txn(5'b11100, 5'd0,  32'h44,  2, 3, 32'h0,        3'b010, 1'b0); // flush in BR
    run_txn(5'b00101, 5'd8,  32'h0,   2, 4, 32'h0,        3'b000, 1'b0); // flush in IDLE
    run_txn(5'b00110, 5'd9,  32'h0,   3, 0, 32'h00001234, 3'b000, 1'b1); // done in ISSUE ignored
    run_txn(5'b00111, 5'd10, 32'h0,   9, 1, 32'h0,        3'b000, 1'b0); // flush in WAIT

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        op = 5'($urandom);
      end else begin
        k  = int'($urandom_range(0, 15));
        op = (k < 7) ? 5'(k + 1) : (k < 13) ? 5'(k + 10) : 5'(k + 15);
      end
      k = int'($urandom_range(0, 9));
      run_txn(op, 5'($urandom), $urandom, int'($urandom_range(1, 6)),
              (k < 6) ? 0 : k - 5, $urandom, 3'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of WAIT
    a = cyc;
    push_ev(a + 1, P_START, 7'b0000001, 1'b0, 5'd0, 32'd0, 1'b0);
    $display("txn cycle=%0d op=00001 reset during WAIT", a);
    bus.iss_valid  = 1'b1;
    bus.iss_opcode = 5'b00001;
    bus.iss_rd     = 5'd9;
    @(posedge clk); #1;
    bus.iss_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("sel_before_reset", 128'({bus.unit_sel, bus.unit_imm}), 128'(8'b00000010));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 128'(reg_outs()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("quiet_after_reset", 128'(reg_outs()), 128'(0));
      check("ready_after_midreset", 128'(bus.iss_ready), 128'(1));
    end
    @(posedge clk); #1;
    run_txn(5'b00001, 5'd12, 32'h0, 1, 0, 32'hcafef00d, 3'b000, 1'b0);

    repeat (4) @(posedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_events: got %0d pending required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
